// File: rtl/riscv32_fetch_unit.sv
// RV32 instruction-fetch stage: owns the fetch PC, issues credit-limited word
// requests to instruction memory and buffers responses in order toward IF/ID.
module riscv32_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        async_rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [31:0]      NOP      = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] o_cnt;
    logic [CNT_W-1:0] k_cnt;
    logic [CNT_W-1:0] f_cnt;

    logic [31:0]      tag_q     [FIFO_DEPTH];
    logic [PTR_W-1:0] tag_wr;
    logic [PTR_W-1:0] tag_rd;

    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [CNT_W:0]   credit_used;
    logic [31:0]      redirect_tgt;
    logic             req_fire;
    logic             push;
    logic             pop;

    // Outstanding requests plus buffered entries never exceed the buffer size,
    // so every response is guaranteed a slot.
    assign credit_used    = {1'b0, o_cnt} + {1'b0, f_cnt};
    assign redirect_tgt   = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid = !async_rst && !redirect_valid && (credit_used < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push           = imem_rsp_valid && !redirect_valid && (k_cnt == '0);
    assign if_valid       = (f_cnt != '0) && !redirect_valid;
    assign pop            = if_valid && if_ready;

    assign if_pc          = (f_cnt != '0) ? fifo_pc[rd_ptr]   : 32'h0000_0000;
    assign if_inst        = (f_cnt != '0) ? fifo_inst[rd_ptr] : NOP;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            fetch_pc <= RESET_PC;
            o_cnt    <= '0;
            k_cnt    <= '0;
            f_cnt    <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            o_cnt <= o_cnt + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (req_fire)       tag_wr <= ptr_inc(tag_wr);
            if (imem_rsp_valid) tag_rd <= ptr_inc(tag_rd);

            if (redirect_valid) begin
                // Everything still in flight after this cycle's response is stale.
                fetch_pc <= redirect_tgt;
                k_cnt    <= o_cnt - CNT_W'(imem_rsp_valid);
                f_cnt    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid && (k_cnt != '0)) k_cnt <= k_cnt - CNT_ONE;
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop)      f_cnt <= f_cnt + CNT_ONE;
                else if (!push && pop) f_cnt <= f_cnt - CNT_ONE;
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]   <= tag_q[tag_rd];
            fifo_inst[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_riscv32_fetch_unit.sv
// Directed bench for riscv32_fetch_unit with a latency-programmable memory
// model and an in-order scoreboard of expected {pc, inst} outputs.
module tb_riscv32_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 3;

    logic        clk = 1'b0;
    logic        async_rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    riscv32_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .async_rst(async_rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_inst(if_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          n_vec   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    int          mem_lat = 1;
    int          hs_cnt  = 0;
    int          hs0;
    logic [31:0] held_addr;
    logic [31:0] exp_q [$];
    mreq_t       mq [$];
    logic [31:0] exp_req   = RST_PC;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_addr = 32'h0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"},  imem_req_addr, RST_PC);
        check({tag, "_if_valid"},  32'(if_valid), 32'd0);
        check({tag, "_if_pc"},     if_pc, 32'h0);
        check({tag, "_if_inst"},   if_inst, 32'h0000_0013);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if_valid(input string tag, input int max);
        int i;
        i = 0;
        while (!if_valid && i < max) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(if_valid), 32'd1);
    endtask

    // Memory responder: fixed latency per request, answers in request order.
    always @(posedge clk) begin
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        if (async_rst) begin
            mq.delete();
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mq[0].addr);
            void'(mq.pop_front());
        end
    end

    // Monitor: output scoreboard, redirect rules, request order and hold rules.
    always @(negedge clk) begin
        if (async_rst) begin
            exp_q.delete();
            mq.delete();
            exp_req   = RST_PC;
            hold_pend = 1'b0;
        end else begin
            if (if_valid && if_ready) begin
                hs_cnt++;
                check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("out_pc", if_pc, exp_q[0]);
                    check("out_inst", if_inst, inst_of(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (redirect_valid) begin
                check("redir_if_valid", 32'(if_valid), 32'd0);
                check("redir_req_valid", 32'(imem_req_valid), 32'd0);
                exp_q.delete();
                exp_req = redirect_pc & 32'hFFFF_FFFC;
            end
            if (hold_pend && !redirect_valid) begin
                check("hold_valid", 32'(imem_req_valid), 32'd1);
                check("hold_addr", imem_req_addr, hold_addr);
            end
            hold_pend = imem_req_valid && !imem_req_ready;
            hold_addr = imem_req_addr;
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_req);
                exp_q.push_back(exp_req);
                mq.push_back('{imem_req_addr, cyc + mem_lat});
                exp_req = exp_req + 32'd4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        async_rst      = 1'b1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #3;
        check_reset_outputs("reset");

        // Streaming with 1-cycle memory: latency and throughput.
        repeat (2) @(posedge clk);
        #2 async_rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RST_PC);
        @(negedge clk);
        check("lat_n1_if_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("lat_n2_if_valid", 32'(if_valid), 32'd1);
        check("lat_n2_if_pc", if_pc, RST_PC);
        tick();
        hs0 = hs_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("throughput_10", 32'(hs_cnt - hs0), 32'd10);

        // Downstream stall fills the buffer and stops requests.
        if_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("stall_f_cnt", 32'(dut.f_cnt), 32'(DEPTH));
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_if_valid", 32'(if_valid), 32'd1);
        tick();
        if_ready = 1'b1;
        repeat (8) tick();

        // Memory ready pattern 1,0,0,1.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        held_addr = imem_req_addr;
        check("toggle_valid0", 32'(imem_req_valid), 32'd1);
        tick();
        @(negedge clk);
        check("toggle_hold1", imem_req_addr, held_addr);
        tick();
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("toggle_accept", imem_req_addr, held_addr);
        tick();

        // 3-cycle memory, two requests in flight, then redirect to 0x2002.
        imem_req_ready = 1'b0;
        repeat (6) tick();
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        @(negedge clk);
        check("redir3_o_cnt", 32'(dut.o_cnt), 32'd2);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir3_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir3_req_addr", imem_req_addr, 32'h0000_2000);
        check("redir3_k_cnt", 32'(dut.k_cnt), 32'd2);
        wait_if_valid("redir3_if_timeout", 12);
        check("redir3_first_pc", if_pc, 32'h0000_2000);

        // Redirect coinciding with a response while entries are buffered.
        tick();
        imem_req_ready = 1'b0;
        repeat (8) tick();
        mem_lat        = 1;
        if_ready       = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        @(negedge clk);
        check("same_pre_f_cnt", 32'(dut.f_cnt), 32'd2);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("same_f_cnt", 32'(dut.f_cnt), 32'd0);
        check("same_k_cnt", 32'(dut.k_cnt), 32'd0);
        check("same_if_valid", 32'(if_valid), 32'd0);
        check("same_req_addr", imem_req_addr, 32'h0000_3000);
        tick();
        if_ready = 1'b1;
        @(negedge clk);
        wait_if_valid("same_if_timeout", 8);
        check("same_first_pc", if_pc, 32'h0000_3000);

        // Asynchronous reset with two requests outstanding.
        tick();
        imem_req_ready = 1'b0;
        repeat (8) tick();
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        #2 async_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check("midrst_o_cnt", 32'(dut.o_cnt), 32'd0);
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        tick();
        tick();
        #1 async_rst = 1'b0;
        @(negedge clk);
        check("restart_req_valid", 32'(imem_req_valid), 32'd1);
        check("restart_req_addr", imem_req_addr, RST_PC);
        wait_if_valid("restart_if_timeout", 8);
        check("restart_first_pc", if_pc, RST_PC);

        // Unaligned redirect near the top of the address space; PC wraps to 0.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        repeat (8) tick();

        // Drain: every accepted request must have come out exactly once.
        imem_req_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        check("drain_if_valid", 32'(if_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
